// File: rtl/var_dt_pkg.sv
// Shared types for the variable-timestep scheduler: default widths,
// dt / emulated-time types and the scheduler state encoding.
package var_dt_pkg;

    localparam int DT_WIDTH_DEF   = 25;
    localparam int TIME_WIDTH_DEF = 48;

    typedef logic [DT_WIDTH_DEF-1:0]   dt_t;
    typedef logic [TIME_WIDTH_DEF-1:0] emu_time_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } sched_state_e;

endpackage

// File: rtl/var_dt_min_tree.sv
// Combinational minimum over the valid requester timesteps.
// min_dt_o is all-ones when nothing is valid; any_valid_o qualifies it.
module var_dt_min_tree #(
    parameter int N = 4,
    parameter int W = 25
) (
    input  logic [N-1:0]   valid_i,
    input  logic [N*W-1:0] dt_i,
    output logic [W-1:0]   min_dt_o,
    output logic           any_valid_o
);

    always_comb begin
        min_dt_o    = '1;
        any_valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i]) begin
                any_valid_o = 1'b1;
                if (dt_i[i*W +: W] < min_dt_o) begin
                    min_dt_o = dt_i[i*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/var_dt_scheduler.sv
// Variable-timestep scheduler: issues the smallest requested dt, clamped to
// DT_MAX and to the time left before stop. Define VAR_DT_STEP_COUNT_EN to add step_count_o.
//
// state | meaning
// IDLE  | stopped, waiting for start (ignored after a livelock error)
// RUN   | a step is taken on every edge with stall low
// PAUSE | host stall, all outputs frozen
// DONE  | emulated time reached the latched stop
module var_dt_scheduler
    import var_dt_pkg::*;
#(
    parameter int          N_REQ      = 4,
    parameter int          DT_WIDTH   = DT_WIDTH_DEF,
    parameter int          TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int unsigned DT_MAX     = 2**(DT_WIDTH-1),
    parameter int          ZERO_LIMIT = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      stall_i,
    input  logic [TIME_WIDTH-1:0]     stop_time_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*DT_WIDTH-1:0] req_dt_i,
    output logic [DT_WIDTH-1:0]       dt_out_o,
    output logic                      step_en_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic [TIME_WIDTH-1:0]     emu_time_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      zero_err_o
`ifdef VAR_DT_STEP_COUNT_EN
    ,
    output logic [31:0]               step_count_o
`endif
);

    localparam int                    ZW       = $clog2(ZERO_LIMIT + 1);
    localparam logic [DT_WIDTH-1:0]   DT_MAX_C = DT_WIDTH'(DT_MAX);
    localparam logic [TIME_WIDTH-1:0] DT_MAX_T = TIME_WIDTH'(DT_MAX);
    localparam logic [ZW-1:0]         ZLIM_C   = ZW'(ZERO_LIMIT);

    sched_state_e state_q, state_d;

    logic [DT_WIDTH-1:0]   dt_q, dt_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [TIME_WIDTH-1:0] stop_q, stop_d;
    logic [ZW-1:0]         zcnt_q, zcnt_d;
    logic                  zero_err_q, zero_err_d;

    logic                  step_take, arm_run, reach_stop, zero_hit;
    logic [TIME_WIDTH-1:0] time_adv, base_time, calc_stop, gap;
    logic [DT_WIDTH-1:0]   rem_dt, min_dt, dt_next;
    logic                  any_valid;
    logic [N_REQ-1:0]      grant_next;
    logic [ZW-1:0]         zcnt_next;

    var_dt_min_tree #(
        .N (N_REQ),
        .W (DT_WIDTH)
    ) u_min_tree (
        .valid_i     (req_valid_i),
        .dt_i        (req_dt_i),
        .min_dt_o    (min_dt),
        .any_valid_o (any_valid)
    );

    assign step_take  = (state_q == RUN) && !stall_i && !abort_i;
    assign arm_run    = (state_q == IDLE || state_q == DONE) && start_i && !zero_err_q
                        && !abort_i && (stop_time_i > time_q);
    assign time_adv   = time_q + TIME_WIDTH'(dt_q);
    assign reach_stop = (time_adv == stop_q);
    assign zcnt_next  = (dt_q == '0) ? zcnt_q + ZW'(1) : '0;
    assign zero_hit   = (dt_q == '0) && (zcnt_next == ZLIM_C);

    // The next dt is measured from where the upcoming step starts: the
    // current time when arming, the advanced time while running.
    always_comb begin
        base_time = (state_q == RUN) ? time_adv : time_q;
        calc_stop = (state_q == RUN) ? stop_q : stop_time_i;
        gap       = (calc_stop > base_time) ? calc_stop - base_time : '0;
        rem_dt    = (gap > DT_MAX_T) ? DT_MAX_C : gap[DT_WIDTH-1:0];
        dt_next   = (rem_dt < DT_MAX_C) ? rem_dt : DT_MAX_C;
        if (any_valid && (min_dt < dt_next)) begin
            dt_next = min_dt;
        end
        grant_next = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_next[i] = req_valid_i[i] && (req_dt_i[i*DT_WIDTH +: DT_WIDTH] == dt_next);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i && !zero_err_q) begin
                        state_d = (stop_time_i > time_q) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (stall_i) begin
                        state_d = PAUSE;
                    end else if (reach_stop) begin
                        state_d = DONE;
                    end else if (zero_hit) begin
                        state_d = IDLE;
                    end
                end
                PAUSE: begin
                    if (!stall_i) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // step_en is the one combinational path: stall must gate the model in the same cycle.
    always_comb begin
        step_en_o = (state_q == RUN) && !stall_i;
        busy_o    = (state_q == RUN) || (state_q == PAUSE);
        done_o    = (state_q == DONE);
    end

    always_comb begin
        dt_d       = dt_q;
        grant_d    = grant_q;
        time_d     = time_q;
        stop_d     = stop_q;
        zcnt_d     = zcnt_q;
        zero_err_d = zero_err_q;
        if (abort_i) begin
            dt_d    = '0;
            grant_d = '0;
        end else if (arm_run) begin
            stop_d  = stop_time_i;
            dt_d    = dt_next;
            grant_d = grant_next;
        end else if (step_take) begin
            time_d = time_adv;
            zcnt_d = zcnt_next;
            if (reach_stop || zero_hit) begin
                dt_d    = '0;
                grant_d = '0;
            end else begin
                dt_d    = dt_next;
                grant_d = grant_next;
            end
            if (!reach_stop && zero_hit) begin
                zero_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dt_q       <= '0;
            grant_q    <= '0;
            time_q     <= '0;
            stop_q     <= '0;
            zcnt_q     <= '0;
            zero_err_q <= 1'b0;
        end else begin
            dt_q       <= dt_d;
            grant_q    <= grant_d;
            time_q     <= time_d;
            stop_q     <= stop_d;
            zcnt_q     <= zcnt_d;
            zero_err_q <= zero_err_d;
        end
    end

    assign dt_out_o   = dt_q;
    assign grant_o    = grant_q;
    assign emu_time_o = time_q;
    assign zero_err_o = zero_err_q;

`ifdef VAR_DT_STEP_COUNT_EN
    logic [31:0] step_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_cnt_q <= '0;
        end else if (arm_run && (state_q == IDLE)) begin
            step_cnt_q <= '0;
        end else if (step_take && (step_cnt_q != '1)) begin
            step_cnt_q <= step_cnt_q + 32'd1;
        end
    end

    assign step_count_o = step_cnt_q;
`endif

endmodule

// File: tb/tb_var_dt_scheduler.sv
// Scoreboarded bench for var_dt_scheduler: directed scenarios plus random
// traffic, checked against an arithmetic reference model.
module tb_var_dt_scheduler;

    localparam int NR   = 4;
    localparam int DTW  = 8;
    localparam int TW   = 16;
    localparam int DMAX = 30;
    localparam int ZLIM = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic            clk;
    logic            rst, start, abort, stall;
    logic [TW-1:0]   stop_time;
    logic [NR-1:0]   req_valid;
    logic [DTW-1:0]  rq [NR];
    logic [NR*DTW-1:0] req_dt;
    logic [DTW-1:0]  dt_out;
    logic            step_en;
    logic [NR-1:0]   grant;
    logic [TW-1:0]   emu_time;
    logic            busy, done, zero_err;
`ifdef VAR_DT_STEP_COUNT_EN
    logic [31:0]     step_count;
`endif

    assign req_dt = {rq[3], rq[2], rq[1], rq[0]};

    var_dt_scheduler #(
        .N_REQ(NR), .DT_WIDTH(DTW), .TIME_WIDTH(TW), .DT_MAX(DMAX), .ZERO_LIMIT(ZLIM)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .stall_i(stall),
        .stop_time_i(stop_time), .req_valid_i(req_valid), .req_dt_i(req_dt),
        .dt_out_o(dt_out), .step_en_o(step_en), .grant_o(grant), .emu_time_o(emu_time),
        .busy_o(busy), .done_o(done), .zero_err_o(zero_err)
`ifdef VAR_DT_STEP_COUNT_EN
        , .step_count_o(step_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DTW-1:0] dt;
        logic [NR-1:0]  g;
        logic [TW-1:0]  t;
        logic           se, busy, done, zerr;
    } exp_t;

    exp_t expq[$];

    // Reference model state
    int          m_mode;
    longint      m_time, m_stop;
    int          m_dt, m_zc;
    logic [NR-1:0] m_g;
    bit          m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Smallest of DT_MAX, time left, and all valid requests.
    function automatic void model_next(input longint base, input longint stp,
                                       output int d, output logic [NR-1:0] g);
        longint rem;
        rem = (stp > base) ? stp - base : 0;
        d = (rem < DMAX) ? int'(rem) : DMAX;
        for (int i = 0; i < NR; i++)
            if (req_valid[i] && int'(rq[i]) < d) d = int'(rq[i]);
        g = '0;
        for (int i = 0; i < NR; i++)
            g[i] = req_valid[i] && (int'(rq[i]) == d);
    endfunction

    task automatic model_update();
        if (rst) begin
            m_mode = M_IDLE; m_time = 0; m_stop = 0; m_dt = 0; m_g = '0; m_zc = 0; m_err = 0;
        end else if (abort) begin
            m_mode = M_IDLE; m_dt = 0; m_g = '0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (start && !m_err) begin
                        if (longint'(stop_time) > m_time) begin
                            m_stop = longint'(stop_time);
                            model_next(m_time, m_stop, m_dt, m_g);
                            m_mode = M_RUN;
                        end else begin
                            m_mode = M_DONE;
                        end
                    end
                end
                M_RUN: begin
                    if (stall) m_mode = M_PAUSE;
                    else begin
                        m_time += m_dt;
                        m_zc = (m_dt == 0) ? m_zc + 1 : 0;
                        if (m_time == m_stop) begin
                            m_mode = M_DONE; m_dt = 0; m_g = '0;
                        end else if (m_zc >= ZLIM) begin
                            m_err = 1; m_mode = M_IDLE; m_dt = 0; m_g = '0;
                        end else begin
                            model_next(m_time, m_stop, m_dt, m_g);
                        end
                    end
                end
                default: if (!stall) m_mode = M_RUN;
            endcase
        end
    endtask

    // Push what the DUT should show this cycle, then advance one edge.
    task automatic tick();
        exp_t e;
        e.dt   = DTW'(m_dt);
        e.g    = m_g;
        e.t    = TW'(m_time);
        e.se   = (m_mode == M_RUN) && !stall;
        e.busy = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        e.done = (m_mode == M_DONE);
        e.zerr = m_err;
        expq.push_back(e);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input logic [NR-1:0] v, input int a, input int b, input int c, input int d);
        req_valid = v;
        rq[0] = DTW'(a); rq[1] = DTW'(b); rq[2] = DTW'(c); rq[3] = DTW'(d);
    endtask

    task automatic idle_in();
        rst = 0; start = 0; abort = 0; stall = 0;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; abort = 0; stall = 0;
        tick();
        rst = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("dt_out",   dt_out,   e.dt);
                chk("grant",    grant,    e.g);
                chk("emu_time", emu_time, e.t);
                chk("step_en",  step_en,  e.se);
                chk("busy",     busy,     e.busy);
                chk("done",     done,     e.done);
                chk("zero_err", zero_err, e.zerr);
            end
        end
    end

    initial begin : stim
        int r;
        longint s;
        rst = 1; start = 0; abort = 0; stall = 0; stop_time = '0;
        set_req('0, 0, 0, 0, 0);
        m_mode = M_IDLE; m_time = 0; m_stop = 0; m_dt = 0; m_g = '0; m_zc = 0; m_err = 0;
        @(posedge clk);
        model_update();
        #1;
        idle_in();
        tick();

        // Basic run: 30,30,30,10 to reach 100
        stop_time = 16'd100; start = 1;
        tick();
        chk("basic_first_dt", dt_out, 30);
        start = 0;
        repeat (4) tick();
        chk("basic_done", done, 1);
        chk("basic_time", emu_time, 100);
        chk("basic_dt_cleared", dt_out, 0);

        // Min selection with a tie
        do_reset();
        set_req(4'b1111, 12, 5, 5, 20);
        stop_time = 16'd1000; start = 1;
        tick();
        chk("min_dt", dt_out, 5);
        chk("min_grant", grant, 4'b0110);
        start = 0;
        repeat (2) tick();

        // Stall three cycles
        stall = 1;
        repeat (3) tick();
        chk("stall_time", emu_time, 10);
        chk("stall_dt", dt_out, 5);
        chk("stall_grant", grant, 4'b0110);
        chk("stall_step_en", step_en, 0);
        stall = 0;
        repeat (3) tick();

        // Livelock on a held zero request
        do_reset();
        set_req(4'b0001, 0, 0, 0, 0);
        stop_time = 16'd1000; start = 1;
        tick();
        start = 0;
        repeat (ZLIM) tick();
        chk("livelock_err", zero_err, 1);
        chk("livelock_idle", busy, 0);
        start = 1;
        repeat (2) tick();
        chk("livelock_start_ignored", busy, 0);
        chk("livelock_dt", dt_out, 0);

        // Abort at 60, re-arm to 90
        do_reset();
        set_req('0, 0, 0, 0, 0);
        stop_time = 16'd1000; start = 1;
        tick();
        start = 0;
        repeat (2) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_time", emu_time, 60);
        chk("abort_idle", busy, 0);
        stop_time = 16'd90; start = 1;
        tick();
        start = 0;
        tick();
        chk("rearm_done", done, 1);
        chk("rearm_time", emu_time, 90);

        // Stop not ahead of time goes straight to DONE; reset mid-run
        stop_time = 16'd50; start = 1;
        tick();
        start = 0;
        stop_time = 16'd500; start = 1;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_time", emu_time, 0);
        chk("rst_dt", dt_out, 0);
        chk("rst_busy", busy, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0) || (m_time > 60000) ||
                    (m_err && $urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 4) == 0);
            start = ($urandom_range(0, 3) == 0);
            s = m_time + longint'($urandom_range(0, 150));
            stop_time = (s > 65535) ? 16'hFFFF : TW'(s);
            if (m_mode != M_PAUSE && $urandom_range(0, 1) == 0) begin
                req_valid = NR'($urandom_range(0, 15));
                for (int i = 0; i < NR; i++) begin
                    r = $urandom_range(1, 40);
                    if ($urandom_range(0, 19) == 0) r = 0;
                    rq[i] = DTW'(r);
                end
            end
            tick();
        end

        idle_in();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/var_dt_scheduler.md
Name: var_dt_scheduler

Overview:
- Variable-timestep scheduler for msdsl emulation models that take a `dt` input, such as an analog model stepped by an svreal fixed-point `dt`.
- Each emulation step it collects the next-event timestep requests from N requesters (stimulus sources, comparators, model blocks). It issues the smallest one, clamped to `DT_MAX` and to the time remaining before `stop_time`.
- It also advances emulated time, gates the model clock enable, and flags which requesters' events fire at the end of the step.
- It sits between the testbench/host control and the model's `dt`/clock-enable inputs.

Parameters:
- `N_REQ`, 4, number of timestep requesters (1..16).
- `DT_WIDTH`, 25, width of unsigned fixed-point `dt` (LSB = one emulator time quantum, same exponent as the model's `dt` svreal format).
- `TIME_WIDTH`, 48, width of the emulated-time accumulator and `stop_time`.
- `DT_MAX`, 2**(DT_WIDTH-1), upper clamp on any issued `dt`.
- `ZERO_LIMIT`, 8, consecutive zero-`dt` steps tolerated before a livelock error.

Ports:
- `clk`  in  1  single system/emulator clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; in IDLE or DONE, begins or continues a run.
- `abort`  in  1  pulse; returns to IDLE from any state.
- `stall`  in  1  host hold; no step is taken while high.
- `stop_time`  in  TIME_WIDTH  absolute emulated end time; sampled on `start`.
- `req_valid`  in  N_REQ  requester i has a pending event.
- `req_dt`  in  N_REQ*DT_WIDTH  time until requester i's event, relative to the start of the upcoming step.
- `dt_out`  out  DT_WIDTH  timestep for the current step; drives the model `dt`.
- `step_en`  out  1  model clock enable; the model advances by `dt_out` on this clk edge.
- `grant`  out  N_REQ  requester i's event lands at the end of the current step.
- `emu_time`  out  TIME_WIDTH  emulated time at the start of the current step.
- `busy`  out  1  state is RUN or PAUSE.
- `done`  out  1  `emu_time == stop_time`, state DONE.
- `zero_err`  out  1  sticky livelock flag.

Behaviour:
- **Reset:** state IDLE; `dt_out`=0, `step_en`=0, `grant`=0, `emu_time`=0, `busy`=0, `done`=0, `zero_err`=0; latched stop=0; zero counter=0.
- **Next timestep:**
  - `dt_next` = min(`DT_MAX`, remaining, min over valid i of `req_dt[i]`).
  - remaining = latched_stop − time at the start of the next step, saturated to `DT_MAX`.
  - With no valid requests, `dt_next` = min(`DT_MAX`, remaining).
  - `grant_next[i]` = `req_valid[i]` && (`req_dt[i]` == `dt_next`). Ties grant all equal requesters.
- **States:**
  - **IDLE:** `step_en`=0.
    - `start`=1 with `stop_time` > `emu_time`: latch stop, register `dt_next` into `dt_out` and `grant_next` into `grant`, go to RUN.
    - `start`=1 with `stop_time` ≤ `emu_time`: go directly to DONE.
  - **RUN:**
    - `step_en` = ~`stall` (combinational from `stall`; the only non-registered output path).
    - On each edge with `stall`=0: `emu_time` += `dt_out`; `dt_out`/`grant` are reloaded from requests sampled that cycle, with remaining computed against the updated time.
    - `stall`=1: go to PAUSE the same edge; hold `dt_out`, `grant`, `emu_time`.
    - When updated `emu_time` == latched stop: go to DONE; `dt_out`=0, `grant`=0.
  - **PAUSE:** `step_en`=0, all outputs held; `stall`=0 returns to RUN. Requesters must hold `req_dt` stable while stalled.
  - **DONE:** `done`=1, `step_en`=0. `start` with a new `stop_time` > `emu_time` re-arms into RUN; `emu_time` is not cleared.
- **`abort`:** any state goes to IDLE next edge; `dt_out`/`grant` cleared, `emu_time` kept. `abort` has priority over `start` and `stall`.
- **Latency:** a request change in cycle k is reflected in `dt_out`/`grant` at k+1 (one registered stage).
- **Zero `dt`:**
  - Allowed; emulates simultaneous events.
  - A counter increments on every taken step with `dt_out`==0 and clears on any nonzero step.
  - When it reaches `ZERO_LIMIT`: `zero_err`=1 (sticky until `rst`), forced to IDLE.
  - `start` is ignored while `zero_err`=1.
- **Arithmetic:** all unsigned. `emu_time` addition cannot overshoot stop, because of the remaining clamp. `req_dt` > `DT_MAX` is clamped and gets no grant.
- **`rst`** mid-run overrides everything.

Optional Feature:
- Macro `VAR_DT_STEP_COUNT_EN`.
- With it: adds output `step_count` [31:0], counting taken steps (`step_en`=1 edges). Cleared on `rst` and on IDLE→RUN; saturates at all-ones.
- Without it: the port and counter are absent.

Decomposition:
- Package `var_dt_pkg`:
  - `DT_WIDTH` / `TIME_WIDTH` defaults.
  - `typedef` `dt_t`, `emu_time_t`.
  - state enum `sched_state_e` {IDLE, RUN, PAUSE, DONE}.
- Sub-module `var_dt_min_tree`: parameterized combinational min-reduction over valid `req_dt`, returning `min_dt` and `any_valid`. Grant equality compare stays in the top.

Test Plan:
- **Basic run:** `stop_time`=100, `DT_MAX`=30, no requests, `start` → `dt_out` sequence 30,30,30,10; `emu_time` 0,30,60,90 → 100; `done`=1 after the 4th step.
- **Min selection:** `req_dt`={12,5,5,20} all valid, stop=1000 → `dt_out`=5, `grant`=0b0110 the cycle after `start`.
- **Stall:** `stall` high for 3 cycles mid-run → `step_en`=0; `emu_time`, `dt_out`, `grant` frozen; resumes with an identical value.
- **Livelock:** requester 0 holds `req_dt`=0, `ZERO_LIMIT`=8 → 8 zero steps, then `zero_err`=1, IDLE, later `start` ignored.
- **Abort/re-arm:** `abort` at `emu_time`=60 → IDLE, `emu_time`=60; `start` with stop=90 → completes at 90.
- **Reset:** `rst` mid-RUN → all outputs at reset values next edge.
